// File: rtl/cp0_pkg.sv
// cp0_pkg: shared CP0 register addresses, exception codes, write masks and field positions.
package cp0_pkg;
  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
  localparam logic [31:0] STATUS_RST   = 32'h0040_0000;
  localparam int IE_BIT  = 0;
  localparam int EXL_BIT = 1;
  localparam int BEV_BIT = 22;
  localparam int BD_BIT  = 31;
  localparam int TI_BIT  = 30;
  localparam int IM_LO   = 8;
  localparam int IP_LO   = 8;
  typedef enum logic [1:0] {EV_NONE, EV_INT, EV_SYS, EV_ERET} cp0_event_t;
endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare pair with half-rate Count and sticky timer interrupt.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);
  logic        tog;
  logic        upd;
  logic [31:0] count_nx;
  always_comb begin
    count_nx = count_we ? wdata : tog ? count + 32'd1 : count;
    upd = count_we | tog;
  end
  // TI only arms on a Count change so a static Count==Compare does not re-fire after a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      compare <= '0;
      tog     <= 1'b0;
      ti      <= 1'b0;
    end else begin
      count <= count_nx;
      tog   <= count_we ? 1'b0 : ~tog;
      if (compare_we) compare <= wdata;
      ti <= compare_we ? 1'b0 : (upd && count_nx == compare) ? 1'b1 : ti;
    end
  end
endmodule

// File: rtl/cp0_unit.sv
// cp0_unit: CP0 register file and exception sequencer at the commit point.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] BEV_VECTOR  = 32'hBFC0_0380,
  parameter logic [31:0] NORM_VECTOR = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_waddr,
  input  logic [31:0] cp0_wdata,
  input  logic        cp0_re,
  input  logic [4:0]  cp0_raddr,
  output logic [31:0] cp0_rdata,
  input  logic        inst_valid,
  input  logic        exc_syscall,
  input  logic        eret,
  input  logic [31:0] exc_pc,
  input  logic        in_delay_slot,
  input  logic [5:0]  hw_int,
  output logic        exc_req,
  output logic [31:0] exc_target,
  output logic [31:0] status_out,
  output logic [31:0] cause_out,
  output logic [31:0] epc_out,
  output logic        timer_int
);
  logic [31:0] status;
  logic [31:0] epc;
  logic [31:0] count;
  logic [31:0] compare;
  logic        bd;
  logic        ti;
  logic [5:0]  hw_q;
  logic [1:0]  ip_sw;
  logic [4:0]  exc_code;
  logic [7:0]  ip;
  logic        int_pend;
  logic        exc_take;
  logic        wr_ok;
  cp0_event_t  ev;
  always_comb begin
    ip = {hw_q[5] | ti, hw_q[4:0], ip_sw};
    int_pend = status[IE_BIT] & ~status[EXL_BIT] & |(status[IM_LO +: 8] & ip);
    ev = !inst_valid ? EV_NONE : int_pend ? EV_INT : exc_syscall ? EV_SYS : eret ? EV_ERET : EV_NONE;
    exc_take = (ev == EV_INT) || (ev == EV_SYS);
    exc_req = ev != EV_NONE;
    exc_target = (ev == EV_ERET) ? epc : exc_take ? (status[BEV_BIT] ? BEV_VECTOR : NORM_VECTOR) : '0;
    wr_ok = cp0_we & (ev != EV_INT);
    cause_out = {bd, ti, 14'd0, ip, 1'b0, exc_code, 2'b00};
    cp0_rdata = !cp0_re ? '0 :
                cp0_raddr == CP0_COUNT   ? count :
                cp0_raddr == CP0_COMPARE ? compare :
                cp0_raddr == CP0_STATUS  ? status :
                cp0_raddr == CP0_CAUSE   ? cause_out :
                cp0_raddr == CP0_EPC     ? epc : '0;
  end
  assign status_out = status;
  assign epc_out    = epc;
  assign timer_int  = ti;
  cp0_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .count_we  (wr_ok && cp0_waddr == CP0_COUNT),
    .compare_we(wr_ok && cp0_waddr == CP0_COMPARE),
    .wdata     (cp0_wdata),
    .count     (count),
    .compare   (compare),
    .ti        (ti)
  );
  // Exception side effects are applied after MTC0 so they take precedence on shared bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      status   <= STATUS_RST;
      epc      <= '0;
      bd       <= 1'b0;
      hw_q     <= '0;
      ip_sw    <= '0;
      exc_code <= '0;
    end else begin
      hw_q <= hw_int;
      if (wr_ok && cp0_waddr == CP0_STATUS) status <= (status & ~STATUS_WMASK) | (cp0_wdata & STATUS_WMASK);
      if (wr_ok && cp0_waddr == CP0_CAUSE) ip_sw <= cp0_wdata[IP_LO +: 2];
      if (wr_ok && cp0_waddr == CP0_EPC) epc <= cp0_wdata;
      if (exc_take) begin
        status[EXL_BIT] <= 1'b1;
        exc_code <= (ev == EV_INT) ? EXC_INT : EXC_SYS;
        if (!status[EXL_BIT]) begin
          bd  <= in_delay_slot;
          epc <= in_delay_slot ? exc_pc - 32'd4 : exc_pc;
        end
      end
      if (ev == EV_ERET) status[EXL_BIT] <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed self-checking bench for cp0_unit.
module tb_cp0_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cp0_we = 1'b0;
  logic [4:0]  cp0_waddr = '0;
  logic [31:0] cp0_wdata = '0;
  logic        cp0_re = 1'b0;
  logic [4:0]  cp0_raddr = '0;
  logic [31:0] cp0_rdata;
  logic        inst_valid = 1'b0;
  logic        exc_syscall = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] exc_pc = '0;
  logic        in_delay_slot = 1'b0;
  logic [5:0]  hw_int = '0;
  logic        exc_req;
  logic [31:0] exc_target;
  logic [31:0] status_out;
  logic [31:0] cause_out;
  logic [31:0] epc_out;
  logic        timer_int;
  int n_chk = 0;
  int n_err = 0;
  logic [31:0] d;
  logic        req;
  logic [31:0] tgt;

  cp0_unit dut (
    .clk(clk), .rst(rst), .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
    .cp0_re(cp0_re), .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata), .inst_valid(inst_valid),
    .exc_syscall(exc_syscall), .eret(eret), .exc_pc(exc_pc), .in_delay_slot(in_delay_slot),
    .hw_int(hw_int), .exc_req(exc_req), .exc_target(exc_target), .status_out(status_out),
    .cause_out(cause_out), .epc_out(epc_out), .timer_int(timer_int)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    @(negedge clk);
    cp0_re = 1'b1;
    cp0_raddr = a;
    #1 v = cp0_rdata;
    cp0_re = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] v);
    @(negedge clk);
    cp0_we = 1'b1;
    cp0_waddr = a;
    cp0_wdata = v;
    @(negedge clk);
    cp0_we = 1'b0;
  endtask

  task automatic commit(input logic sys, input logic er, input logic [31:0] pc, input logic ds,
                        output logic r, output logic [31:0] t);
    @(negedge clk);
    inst_valid = 1'b1;
    exc_syscall = sys;
    eret = er;
    exc_pc = pc;
    in_delay_slot = ds;
    #1 r = exc_req;
    t = exc_target;
    @(negedge clk);
    inst_valid = 1'b0;
    exc_syscall = 1'b0;
    eret = 1'b0;
    in_delay_slot = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd(5'd9, d);  chk("rst_count", d, 32'h0);
    rd(5'd12, d); chk("rst_status", d, 32'h0040_0000);
    rd(5'd13, d); chk("rst_cause", d, 32'h0);
    rd(5'd14, d); chk("rst_epc", d, 32'h0);
    chk("rst_exc_req", {31'd0, exc_req}, 32'h0);
    wr(5'd12, 32'hFFFF_FFFF);
    rd(5'd12, d); chk("status_mask", d, 32'h0040_FF03);
    wr(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, d); chk("cause_mask", d, 32'h0000_0300);
    wr(5'd13, 32'h0);
    wr(5'd12, 32'h0);
    rd(5'd12, d); chk("status_clr", d, 32'h0040_0000);
    wr(5'd5, 32'hFFFF_FFFF);
    rd(5'd5, d); chk("unmapped", d, 32'h0);
    @(negedge clk);
    cp0_raddr = 5'd12;
    #1 chk("re_low", cp0_rdata, 32'h0);
    commit(1'b1, 1'b0, 32'h8000_1000, 1'b0, req, tgt);
    chk("sys_req", {31'd0, req}, 32'h1);
    chk("sys_tgt", tgt, 32'hBFC0_0380);
    rd(5'd14, d); chk("sys_epc", d, 32'h8000_1000);
    rd(5'd13, d); chk("sys_cause", d, 32'h0000_0020);
    rd(5'd12, d); chk("sys_status", d, 32'h0040_0002);
    commit(1'b0, 1'b1, 32'h0, 1'b0, req, tgt);
    chk("eret_req", {31'd0, req}, 32'h1);
    chk("eret_tgt", tgt, 32'h8000_1000);
    rd(5'd12, d); chk("eret_status", d, 32'h0040_0000);
    commit(1'b1, 1'b0, 32'h8000_1004, 1'b1, req, tgt);
    chk("ds_req", {31'd0, req}, 32'h1);
    rd(5'd14, d); chk("ds_epc", d, 32'h8000_1000);
    rd(5'd13, d); chk("ds_cause", d, 32'h8000_0020);
    commit(1'b1, 1'b0, 32'h8000_2000, 1'b0, req, tgt);
    chk("nest_req", {31'd0, req}, 32'h1);
    chk("nest_tgt", tgt, 32'hBFC0_0380);
    rd(5'd14, d); chk("nest_epc", d, 32'h8000_1000);
    rd(5'd13, d); chk("nest_cause", d, 32'h8000_0020);
    commit(1'b0, 1'b1, 32'h0, 1'b0, req, tgt);
    chk("nest_eret_tgt", tgt, 32'h8000_1000);
    commit(1'b0, 1'b0, 32'h0, 1'b0, req, tgt);
    chk("idle_req", {31'd0, req}, 32'h0);
    chk("idle_tgt", tgt, 32'h0);
    @(negedge clk);
    hw_int = 6'd1;
    #1 chk("hw_lag", cause_out, 32'h8000_0020);
    rd(5'd13, d); chk("hw_ip", d, 32'h8000_0420);
    hw_int = 6'd0;
    wr(5'd12, 32'h0000_8001);
    wr(5'd11, 32'd10);
    wr(5'd9, 32'd0);
    repeat (25) @(negedge clk);
    rd(5'd13, d); chk("ti_cause", d, 32'hC000_8020);
    chk("ti_out", {31'd0, timer_int}, 32'h1);
    @(negedge clk);
    inst_valid = 1'b1;
    exc_pc = 32'h8000_3000;
    cp0_we = 1'b1;
    cp0_waddr = 5'd14;
    cp0_wdata = 32'h1234_5678;
    #1 chk("int_req", {31'd0, exc_req}, 32'h1);
    chk("int_tgt", exc_target, 32'hBFC0_0380);
    @(negedge clk);
    inst_valid = 1'b0;
    cp0_we = 1'b0;
    rd(5'd14, d); chk("int_epc", d, 32'h8000_3000);
    rd(5'd13, d); chk("int_cause", d, 32'h4000_8000);
    rd(5'd12, d); chk("int_status", d, 32'h0040_8003);
    wr(5'd11, 32'h100);
    rd(5'd13, d); chk("ti_clr_cause", d, 32'h0);
    chk("ti_clr_out", {31'd0, timer_int}, 32'h0);
    wr(5'd9, 32'hFFFF_FFFF);
    rd(5'd9, d); chk("wrap_hold", d, 32'hFFFF_FFFF);
    rd(5'd9, d); chk("wrap_zero", d, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
